// File: rtl/hack_run_controller.sv
// Run/halt supervisor for the Hack computer. It holds the CPU in reset for a
// boot interval, then lets it run and counts cycles. It stops the run when it
// sees the end-of-program tight loop, or when the watchdog expires.
module hack_run_controller #(
   parameter int ADDR_W      = 15,
   parameter int CNT_W       = 24,
   parameter int BOOT_CYCLES = 4,
   parameter int HALT_REPEAT = 8,
   parameter int MAX_CYCLES  = 20000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic              ram_store,
   output logic              cpu_reset,
   output logic              running,
   output logic              halted,
   output logic              timed_out,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [ADDR_W-1:0] halt_pc
);

   localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int REP_W  = $clog2(HALT_REPEAT + 1);

   typedef enum logic [2:0] {
      IDLE,
      BOOT,
      RUN,
      HALTED,
      TIMEOUT
   } state_t;

   state_t            state_q, state_d;
   logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
   logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
   logic [ADDR_W-1:0] pc_d1_q, pc_d1_d;
   logic [ADDR_W-1:0] pc_d2_q, pc_d2_d;
   logic [1:0]        hist_valid_q, hist_valid_d;
   logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
   logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              running_q, running_d;
   logic              halted_q, halted_d;
   logic              timed_out_q, timed_out_d;
   logic              match;

   // Next-state logic: sequencing, loop detection, watchdog and registered status flags.
   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      rep_cnt_d     = rep_cnt_q;
      pc_d1_d       = pc_d1_q;
      pc_d2_d       = pc_d2_q;
      hist_valid_d  = hist_valid_q;
      cycle_count_d = cycle_count_q;
      halt_pc_d     = halt_pc_q;

      // A PC that equals the one from two cycles ago, with no store in between,
      // covers both the one-instruction and the two-instruction end loop.
      match = (hist_valid_q == 2'd2) && (instr_addr == pc_d2_q) && !ram_store;

      case (state_q)
         IDLE, HALTED, TIMEOUT: begin
            if (start) begin
               state_d       = BOOT;
               boot_cnt_d    = '0;
               rep_cnt_d     = '0;
               pc_d1_d       = '0;
               pc_d2_d       = '0;
               hist_valid_d  = 2'd0;
               cycle_count_d = '0;
               halt_pc_d     = '0;
            end
         end
         BOOT: begin
            if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               boot_cnt_d = boot_cnt_q + BOOT_W'(1);
            end
         end
         RUN: begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
            pc_d1_d       = instr_addr;
            pc_d2_d       = pc_d1_q;
            hist_valid_d  = (hist_valid_q == 2'd2) ? 2'd2 : hist_valid_q + 2'd1;
            rep_cnt_d     = match ? rep_cnt_q + REP_W'(1) : '0;
            // Halt is checked first so it wins when both land on the same cycle.
            if (match && (rep_cnt_q == REP_W'(HALT_REPEAT - 1))) begin
               state_d   = HALTED;
               halt_pc_d = instr_addr;
            end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
               state_d = TIMEOUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cpu_reset_d = (state_d != RUN);
      running_d   = (state_d == RUN);
      halted_d    = (state_d == HALTED);
      timed_out_d = (state_d == TIMEOUT);
   end

   // State and datapath registers; reset overrides every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         boot_cnt_q    <= '0;
         rep_cnt_q     <= '0;
         pc_d1_q       <= '0;
         pc_d2_q       <= '0;
         hist_valid_q  <= 2'd0;
         cycle_count_q <= '0;
         halt_pc_q     <= '0;
         cpu_reset_q   <= 1'b1;
         running_q     <= 1'b0;
         halted_q      <= 1'b0;
         timed_out_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         boot_cnt_q    <= boot_cnt_d;
         rep_cnt_q     <= rep_cnt_d;
         pc_d1_q       <= pc_d1_d;
         pc_d2_q       <= pc_d2_d;
         hist_valid_q  <= hist_valid_d;
         cycle_count_q <= cycle_count_d;
         halt_pc_q     <= halt_pc_d;
         cpu_reset_q   <= cpu_reset_d;
         running_q     <= running_d;
         halted_q      <= halted_d;
         timed_out_q   <= timed_out_d;
      end
   end

   assign cpu_reset   = cpu_reset_q;
   assign running     = running_q;
   assign halted      = halted_q;
   assign timed_out   = timed_out_q;
   assign cycle_count = cycle_count_q;
   assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_hack_run_controller.sv
// Bench for hack_run_controller: directed scenarios plus random traffic,
// all compared against a behavioural model of the run supervisor.
module tb_hack_run_controller;

   localparam int ADDR_W      = 15;
   localparam int CNT_W       = 24;
   localparam int BOOT_CYCLES = 4;
   localparam int HALT_REPEAT = 8;
   localparam int MAX_CYCLES  = 50;

   localparam int M_IDLE    = 0;
   localparam int M_BOOT    = 1;
   localparam int M_RUN     = 2;
   localparam int M_HALTED  = 3;
   localparam int M_TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] instr_addr;
   logic              ram_store;
   logic              cpu_reset;
   logic              running;
   logic              halted;
   logic              timed_out;
   logic [CNT_W-1:0]  cycle_count;
   logic [ADDR_W-1:0] halt_pc;

   int compared   = 0;
   int mismatched = 0;

   int mMode;
   int mBootSeen;
   int mCount;
   int mHaltPc;
   int mStreak;
   int mHist[$];

   hack_run_controller #(
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W),
      .BOOT_CYCLES(BOOT_CYCLES),
      .HALT_REPEAT(HALT_REPEAT),
      .MAX_CYCLES (MAX_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .instr_addr (instr_addr),
      .ram_store  (ram_store),
      .cpu_reset  (cpu_reset),
      .running    (running),
      .halted     (halted),
      .timed_out  (timed_out),
      .cycle_count(cycle_count),
      .halt_pc    (halt_pc)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mMode     = M_IDLE;
      mBootSeen = 0;
      mCount    = 0;
      mHaltPc   = 0;
      mStreak   = 0;
      mHist.delete();
   endtask

   // Behavioural model: advances by one clock edge with the inputs that edge saw.
   task automatic modelStep(input logic rst, input logic st, input int pc, input logic store);
      bit isMatch;
      if (rst) begin
         modelReset();
         return;
      end
      case (mMode)
         M_IDLE, M_HALTED, M_TIMEOUT: begin
            if (st) begin
               mMode     = M_BOOT;
               mBootSeen = 1;
               mCount    = 0;
               mHaltPc   = 0;
               mStreak   = 0;
               mHist.delete();
            end
         end
         M_BOOT: begin
            if (mBootSeen == BOOT_CYCLES) mMode = M_RUN;
            else mBootSeen++;
         end
         M_RUN: begin
            mCount++;
            isMatch = (mHist.size() >= 2) && (pc == mHist[mHist.size()-2]) && !store;
            mStreak = isMatch ? mStreak + 1 : 0;
            mHist.push_back(pc);
            if (mHist.size() > 2) void'(mHist.pop_front());
            if (mStreak == HALT_REPEAT) begin
               mMode   = M_HALTED;
               mHaltPc = pc;
            end else if (mCount == MAX_CYCLES) begin
               mMode = M_TIMEOUT;
            end
         end
         default: ;
      endcase
   endtask

   task automatic compareAll();
      checkOutput("cpu_reset",   {31'd0, cpu_reset}, (mMode != M_RUN) ? 32'd1 : 32'd0);
      checkOutput("running",     {31'd0, running},   (mMode == M_RUN) ? 32'd1 : 32'd0);
      checkOutput("halted",      {31'd0, halted},    (mMode == M_HALTED) ? 32'd1 : 32'd0);
      checkOutput("timed_out",   {31'd0, timed_out}, (mMode == M_TIMEOUT) ? 32'd1 : 32'd0);
      checkOutput("cycle_count", 32'(cycle_count),   32'(mCount));
      checkOutput("halt_pc",     32'(halt_pc),       32'(mHaltPc));
   endtask

   // One clock of stimulus: drive, let the edge happen, update model, check on the falling edge.
   task automatic applyStimulus(input logic rst, input logic st, input int pc, input logic store);
      reset      = rst;
      start      = st;
      instr_addr = pc[ADDR_W-1:0];
      ram_store  = store;
      @(posedge clk);
      modelStep(rst, st, pc, store);
      @(negedge clk);
      compareAll();
   endtask

   // Start pulse followed by the boot interval; lands on the first RUN cycle.
   task automatic bootSequence(input string tag);
      int hi;
      hi = 0;
      applyStimulus(1'b0, 1'b1, 0, 1'b0);
      if (cpu_reset === 1'b1) hi++;
      checkOutput({tag, "_haltPcClr"}, 32'(halt_pc), 32'd0);
      checkOutput({tag, "_flagsClr"}, {30'd0, halted, timed_out}, 32'd0);
      for (int i = 0; i < BOOT_CYCLES; i++) begin
         applyStimulus(1'b0, 1'b0, 0, 1'b0);
         if (cpu_reset === 1'b1) hi++;
      end
      checkOutput({tag, "_bootLen"}, 32'(hi), 32'(BOOT_CYCLES));
      checkOutput({tag, "_runEntry"}, {31'd0, running}, 32'd1);
      checkOutput({tag, "_count0"}, 32'(cycle_count), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      instr_addr = '0;
      ram_store  = 1'b0;
      modelReset();

      // Reset for two cycles, idle, then start on the fifth cycle.
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      checkOutput("resetCpuReset", {31'd0, cpu_reset}, 32'd1);
      checkOutput("resetCount", 32'(cycle_count), 32'd0);
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      bootSequence("boot1");

      // Two-instruction end loop: 0..10 then 11,10,11,...
      for (int i = 0; i < 60 && mMode == M_RUN; i++)
         applyStimulus(1'b0, 1'b0, (i <= 10) ? i : ((i % 2 == 1) ? 11 : 10), 1'b0);
      checkOutput("twoLoopHalted", {31'd0, halted}, 32'd1);
      checkOutput("twoLoopCount", 32'(cycle_count), 32'd20);
      checkOutput("twoLoopPc", 32'(halt_pc), 32'd11);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, i, 1'b1);
      checkOutput("twoLoopFrozen", 32'(cycle_count), 32'd20);

      // Same loop broken by a store every fifth cycle: watchdog must fire.
      bootSequence("store");
      for (int i = 0; i < 60 && mMode == M_RUN; i++)
         applyStimulus(1'b0, 1'b0, (i <= 10) ? i : ((i % 2 == 1) ? 11 : 10), (i % 5 == 4));
      checkOutput("storeTimedOut", {31'd0, timed_out}, 32'd1);
      checkOutput("storeHalted", {31'd0, halted}, 32'd0);
      checkOutput("storeCount", 32'(cycle_count), 32'(MAX_CYCLES));

      // Self loop at PC 7 from the first RUN cycle.
      bootSequence("self");
      for (int i = 0; i < 60 && mMode == M_RUN; i++) applyStimulus(1'b0, 1'b0, 7, 1'b0);
      checkOutput("selfHalted", {31'd0, halted}, 32'd1);
      checkOutput("selfCount", 32'(cycle_count), 32'd10);
      checkOutput("selfPc", 32'(halt_pc), 32'd7);

      // Reset in the middle of a run, then boot again.
      bootSequence("mid");
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, i * 3, 1'b0);
      checkOutput("midCountBefore", 32'(cycle_count), 32'd30);
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      checkOutput("midResetCount", 32'(cycle_count), 32'd0);
      checkOutput("midResetCpu", {31'd0, cpu_reset}, 32'd1);
      checkOutput("midResetFlags", {29'd0, running, halted, timed_out}, 32'd0);
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      bootSequence("reboot");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, i + 1000, 1'b0);
      checkOutput("rebootCount", 32'(cycle_count), 32'd5);
      for (int i = 0; i < 60 && mMode == M_RUN; i++) applyStimulus(1'b0, 1'b0, 7, 1'b0);
      checkOutput("rebootHalted", {31'd0, halted}, 32'd1);

      // Rerun from HALTED with halt and watchdog landing on the same cycle.
      bootSequence("rerun");
      for (int i = 0; i < 60 && mMode == M_RUN; i++)
         applyStimulus(1'b0, 1'b0, (i < 40) ? i + 100 : 500, 1'b0);
      checkOutput("tieHalted", {31'd0, halted}, 32'd1);
      checkOutput("tieTimedOut", {31'd0, timed_out}, 32'd0);
      checkOutput("tieCount", 32'(cycle_count), 32'(MAX_CYCLES));
      checkOutput("tiePc", 32'(halt_pc), 32'd500);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0),
                       ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 3)),
                       ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
